// File: rtl/spi_ram_pkg.sv
// Shared opcodes, arbiter state encoding and parameter defaults for the SPI RAM sequencer.
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SPI_ACC,
        HOST_ACC,
        RD_WAIT
    } arb_state_t;

    localparam int unsigned ADDR_SIZE_DEFAULT = 8;
    localparam int unsigned TX_HOLD_DEFAULT   = ADDR_SIZE_DEFAULT + 1;

    // tx window spans one cycle per address bit plus one
    function automatic int unsigned tx_hold_for(input int unsigned addr_size);
        return addr_size + 1;
    endfunction

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is SPI, bit 1 is host.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_host;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_host ? 2'b01 : 2'b10;
        end
    end

    // Resetting to host makes SPI win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_host <= 1'b1;
        end else if (accept && (gnt != 2'b00)) begin
            last_host <= gnt[1];
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Decodes SPI command words, shares the single-port RAM with a host port and returns SPI read data.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEFAULT,
    parameter int unsigned TX_HOLD   = tx_hold_for(ADDR_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] rx_data,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [ADDR_SIZE-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [ADDR_SIZE-1:0] host_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [ADDR_SIZE-1:0] mem_din,
    input  logic [ADDR_SIZE-1:0] mem_dout
);

    localparam int unsigned CNT_W = $clog2(TX_HOLD + 1);

    arb_state_t           state, state_next;
    logic [1:0]           opcode;
    logic [ADDR_SIZE-1:0] payload;
    logic                 rx_data_op, rx_rd;
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr, spi_wdata;
    logic                 spi_pend, spi_pend_rd;
    logic                 spi_req, spi_req_rd;
    logic [ADDR_SIZE-1:0] spi_req_wdata;
    logic [1:0]           gnt;
    logic                 spi_take, host_take;
    logic                 acc_host, acc_we;
    logic [ADDR_SIZE-1:0] acc_addr, acc_wdata;
    logic [CNT_W-1:0]     tx_cnt;

    assign opcode     = rx_data[ADDR_SIZE+1 -: 2];
    assign payload    = rx_data[ADDR_SIZE-1:0];
    assign rx_data_op = rx_valid && ((opcode == OP_WR_DATA) || (opcode == OP_RD_DATA));
    assign rx_rd      = (opcode == OP_RD_DATA);

    // An arriving data command requests in its own cycle so an idle FSM can start next cycle.
    assign spi_req       = spi_pend || rx_data_op;
    assign spi_req_rd    = rx_data_op ? rx_rd : spi_pend_rd;
    assign spi_req_wdata = rx_data_op ? payload : spi_wdata;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({host_req, spi_req}),
        .accept (state == IDLE),
        .gnt    (gnt)
    );

    assign spi_take  = (state == IDLE) && gnt[0];
    assign host_take = (state == IDLE) && gnt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            rd_addr     <= '0;
            spi_pend    <= 1'b0;
            spi_pend_rd <= 1'b0;
            spi_wdata   <= '0;
        end else begin
            if (rx_valid && (opcode == OP_WR_ADDR)) wr_addr <= payload;
            if (rx_valid && (opcode == OP_RD_ADDR)) rd_addr <= payload;
            if (rx_data_op && !spi_take) begin
                spi_pend    <= 1'b1;
                spi_pend_rd <= rx_rd;
                spi_wdata   <= payload;
            end else if (spi_take) begin
                spi_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_host  <= 1'b0;
            acc_we    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
        end else if (spi_take) begin
            acc_host  <= 1'b0;
            acc_we    <= !spi_req_rd;
            acc_addr  <= spi_req_rd ? rd_addr : wr_addr;
            acc_wdata <= spi_req_wdata;
        end else if (host_take) begin
            acc_host  <= 1'b1;
            acc_we    <= host_we;
            acc_addr  <= host_addr;
            acc_wdata <= host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (gnt[0])      state_next = SPI_ACC;
                else if (gnt[1]) state_next = HOST_ACC;
            end
            SPI_ACC, HOST_ACC: state_next = acc_we ? IDLE : RD_WAIT;
            RD_WAIT:           state_next = IDLE;
            default:           state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_en      = (state == SPI_ACC) || (state == HOST_ACC);
        mem_we      = mem_en && acc_we;
        mem_addr    = mem_en ? acc_addr : '0;
        mem_din     = mem_we ? acc_wdata : '0;
        host_gnt    = (state == HOST_ACC);
        host_rvalid = (state == RD_WAIT) && acc_host;
        host_rdata  = host_rvalid ? mem_dout : '0;
        tx_valid    = (tx_cnt != '0);
    end

    // A fresh SPI read completion reloads the counter, restarting any open window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= '0;
            tx_cnt  <= '0;
        end else if ((state == RD_WAIT) && !acc_host) begin
            tx_data <= mem_dout;
            tx_cnt  <= CNT_W'(TX_HOLD);
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CNT_W'(1);
        end
    end

endmodule
